apple1_sysctl: RTL and testbench

Parametrised CPU clock-enable and reset controller for the Apple-1 top level. It divides `clk25` into a CPU clock enable with a runtime-selectable normal or turbo divisor. It runs a power-up reset sequence and accepts soft-reset requests. It optionally supports single-step gating of the CPU `ready` input. It drives `enable`, `ready` and `reset` of the 6502 core and the enable of clock-qualified peripherals.

---
 rtl/apple1_sysctl.sv | 127 ++++++++++++
 tb/tb_apple1_sysctl.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/apple1_sysctl.sv
// apple1_sysctl: CPU clock-enable divider plus power-up/soft reset sequencer for the Apple-1 top.
// Define SYSCTL_STEP_EN to build the single-step gating of cpu_ready_o.
module apple1_sysctl #(
  parameter int CLK_DIV      = 25,
  parameter int TURBO_DIV    = 5,
  parameter int DIV_W        = 5,
  parameter int RESET_CYCLES = 64,
  parameter int RST_W        = 6
) (
  input  logic clk25_i,
  input  logic reset_i,
  input  logic turbo_i,
  input  logic soft_rst_req_i,
  input  logic step_mode_i,
  input  logic step_req_i,
  output logic cpu_clken_o,
  output logic cpu_ready_o,
  output logic cpu_reset_o,
  output logic running_o
);

  // state    | meaning
  // ST_RESET | CPU held in reset, counting RESET_CYCLES ticks
  // ST_RUN   | CPU running (optionally step-gated)

  localparam logic [DIV_W-1:0] NORM_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] TURBO_LAST = DIV_W'(TURBO_DIV - 1);
  localparam logic [RST_W-1:0] RST_LAST   = RST_W'(RESET_CYCLES - 1);

  typedef enum logic {ST_RESET, ST_RUN} state_t;

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d, div_last;
  logic             turbo_q, turbo_d, fresh_q, turbo_sel;
  logic             clken_q, tick;

  state_t           state_q;
  logic [RST_W-1:0] rst_cnt_q;
  logic             rst_pend_q, cpu_reset_q, running_q;

  // The first period after reset uses the live turbo input; later periods
  // use the value captured at the wrap edge, so a period is never cut short.
  assign turbo_sel = fresh_q ? turbo_i : turbo_q;
  assign div_last  = turbo_sel ? TURBO_LAST : NORM_LAST;
  assign tick      = clken_q;

  always_comb begin
    div_cnt_d = div_cnt_q + DIV_W'(1);
    turbo_d   = fresh_q ? turbo_i : turbo_q;
    if (div_cnt_q == div_last) begin
      div_cnt_d = '0;
      turbo_d   = turbo_i;
    end
  end

  always_ff @(posedge clk25_i or posedge reset_i) begin
    if (reset_i) begin
      div_cnt_q <= '0;
      turbo_q   <= 1'b0;
      fresh_q   <= 1'b1;
      clken_q   <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      turbo_q   <= turbo_d;
      fresh_q   <= 1'b0;
      clken_q   <= (div_cnt_q == '0);
    end
  end

  always_ff @(posedge clk25_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= ST_RESET;
      rst_cnt_q   <= '0;
      rst_pend_q  <= 1'b0;
      cpu_reset_q <= 1'b1;
      running_q   <= 1'b0;
    end else begin
      if (soft_rst_req_i) rst_pend_q <= 1'b1;
      if (tick) begin
        if (rst_pend_q) begin
          // A request landing on the consuming edge is kept for the next tick.
          state_q     <= ST_RESET;
          rst_cnt_q   <= '0;
          rst_pend_q  <= soft_rst_req_i;
          cpu_reset_q <= 1'b1;
          running_q   <= 1'b0;
        end else if (state_q == ST_RESET) begin
          if (rst_cnt_q == RST_LAST) begin
            state_q     <= ST_RUN;
            cpu_reset_q <= 1'b0;
            running_q   <= 1'b1;
          end else begin
            rst_cnt_q <= rst_cnt_q + RST_W'(1);
          end
        end
      end
    end
  end

`ifdef SYSCTL_STEP_EN
  logic step_pend_q, step_gate;

  assign step_gate = (state_q == ST_RUN) && step_mode_i;

  always_ff @(posedge clk25_i or posedge reset_i) begin
    if (reset_i) begin
      step_pend_q <= 1'b0;
    end else if (tick && rst_pend_q) begin
      step_pend_q <= 1'b0;
    end else if (step_req_i) begin
      step_pend_q <= 1'b1;
    end else if (tick && step_gate) begin
      step_pend_q <= 1'b0;
    end
  end

  assign cpu_ready_o = step_gate ? (clken_q & step_pend_q) : clken_q;
`else
  logic unused_step;
  assign unused_step = step_mode_i ^ step_req_i;
  assign cpu_ready_o = clken_q;
`endif

  assign cpu_clken_o = clken_q;
  assign cpu_reset_o = cpu_reset_q;
  assign running_o   = running_q;

endmodule

// File: tb/tb_apple1_sysctl.sv
// Directed bench for apple1_sysctl: divider/turbo timing, reset sequencing, soft reset, step gating.
// Default-parameter instance plus a TURBO_DIV=1 instance running in turbo from reset.
module tb_apple1_sysctl;

  logic clk25 = 1'b0;
  logic reset;
  logic turbo, soft_rst_req, step_mode, step_req;
  logic cpu_clken, cpu_ready, cpu_reset, running;
  logic f_turbo, f_soft;
  logic f_clken, f_ready, f_reset, f_running;

  int n_chk  = 0;
  int n_fail = 0;
  int k      = 0;
  int f_ticks = 0;

  always #5 clk25 = ~clk25;

  apple1_sysctl u_dut (
    .clk25_i        (clk25),
    .reset_i        (reset),
    .turbo_i        (turbo),
    .soft_rst_req_i (soft_rst_req),
    .step_mode_i    (step_mode),
    .step_req_i     (step_req),
    .cpu_clken_o    (cpu_clken),
    .cpu_ready_o    (cpu_ready),
    .cpu_reset_o    (cpu_reset),
    .running_o      (running)
  );

  apple1_sysctl #(.TURBO_DIV(1)) u_fast (
    .clk25_i        (clk25),
    .reset_i        (reset),
    .turbo_i        (f_turbo),
    .soft_rst_req_i (f_soft),
    .step_mode_i    (step_mode),
    .step_req_i     (step_req),
    .cpu_clken_o    (f_clken),
    .cpu_ready_o    (f_ready),
    .cpu_reset_o    (f_reset),
    .running_o      (f_running)
  );

  task automatic check_eq(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s (edge %0d): got %0d, expected %0d", tag, k, got, exp);
    end
  endtask

  // Hand-derived tick schedule: period 25 until the wrap at edge 1600,
  // period 5 until the wrap at edge 2505, then period 25 again.
  function automatic int exp_clken(input int e);
    if (e < 1) return 0;
    if (e <= 1601) return ((e - 1) % 25 == 0) ? 1 : 0;
    if (e <= 2506) return ((e - 1601) % 5 == 0) ? 1 : 0;
    return ((e - 2506) % 25 == 0) ? 1 : 0;
  endfunction

  function automatic int exp_ready(input int e);
`ifdef SYSCTL_STEP_EN
    if (e >= 2504) return (e == 2781) ? 1 : 0;
`endif
    return exp_clken(e);
  endfunction

  task automatic next_edge();
    @(posedge clk25);
    #1;
    k++;
  endtask

  initial begin
    reset        = 1'b1;
    turbo        = 1'b0;
    soft_rst_req = 1'b0;
    step_mode    = 1'b0;
    step_req     = 1'b0;
    f_turbo      = 1'b1;
    f_soft       = 1'b0;

    repeat (2) @(posedge clk25);
    #2;
    check_eq("rst_clken", int'(cpu_clken), 0);
    check_eq("rst_reset", int'(cpu_reset), 1);
    check_eq("rst_ready", int'(cpu_ready), 0);
    check_eq("rst_running", int'(running), 0);
    check_eq("rst_f_clken", int'(f_clken), 0);
    check_eq("rst_f_reset", int'(f_reset), 1);
    @(negedge clk25);
    reset = 1'b0;

    while (k < 2810) begin
      next_edge();
      check_eq("clken", int'(cpu_clken), exp_clken(k));
      check_eq("ready", int'(cpu_ready), exp_ready(k));

      if (k <= 70) begin
        check_eq("f_clken", int'(f_clken), 1);
        if (f_clken && f_reset) f_ticks++;
      end

      case (k)
        64:   check_eq("f_reset_hold", int'(f_reset), 1);
        65: begin
          check_eq("f_reset_fall", int'(f_reset), 0);
          check_eq("f_running", int'(f_running), 1);
        end
        70:   check_eq("f_reset_ticks", f_ticks, 64);
        1576: begin
          check_eq("por_reset_hold", int'(cpu_reset), 1);
          check_eq("por_running_lo", int'(running), 0);
        end
        1577: begin
          check_eq("por_reset_fall", int'(cpu_reset), 0);
          check_eq("por_running_hi", int'(running), 1);
        end
        1706: check_eq("soft1_before", int'(cpu_reset), 0);
        1707: begin
          check_eq("soft1_assert", int'(cpu_reset), 1);
          check_eq("soft1_running", int'(running), 0);
        end
        2026: check_eq("soft1_hold", int'(cpu_reset), 1);
        2027: begin
          check_eq("soft1_release", int'(cpu_reset), 0);
          check_eq("soft1_running", int'(running), 1);
        end
        2031: check_eq("soft2_before", int'(cpu_reset), 0);
        2032: check_eq("soft2_assert", int'(cpu_reset), 1);
        2352: check_eq("restart_hold", int'(cpu_reset), 1);
        2501: check_eq("restart_hold_end", int'(cpu_reset), 1);
        2502: begin
          check_eq("restart_release", int'(cpu_reset), 0);
          check_eq("restart_running", int'(running), 1);
        end
        default: ;
      endcase

      case (k)
        1590: turbo = 1'b1;
        1703, 2030, 2180: soft_rst_req = 1'b1;
        1704, 2031, 2181: soft_rst_req = 1'b0;
        2503: begin
          turbo     = 1'b0;
          step_mode = 1'b1;
        end
        2759, 2764, 2769: step_req = 1'b1;
        2760, 2765, 2770: step_req = 1'b0;
        default: ;
      endcase
    end

    #3;
    reset = 1'b1;
    #1;
    check_eq("async_clken", int'(cpu_clken), 0);
    check_eq("async_reset", int'(cpu_reset), 1);
    check_eq("async_running", int'(running), 0);
    check_eq("async_ready", int'(cpu_ready), 0);
    check_eq("async_f_clken", int'(f_clken), 0);
    next_edge();
    check_eq("async_hold_clken", int'(cpu_clken), 0);
    check_eq("async_hold_reset", int'(cpu_reset), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
